// File: rtl/abc_to_dq_seq_if.sv
// Handshake and data bundle between the phase-current scaler, abc_to_dq_seq and the d/q PI stage.
// Latency: none (wires only).
// Backpressure: in_valid/in_ready on the sample side; out_valid/out_ready on the result side.
interface abc_to_dq_seq_if #(
    parameter int N = 24
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [N-1:0] C;
    logic [N-1:0] CosQ;
    logic [N-1:0] SinQ;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] d;
    logic [N-1:0] q;

    // Producer of samples / consumer of d,q
    modport master (
        output in_valid, A, B, C, CosQ, SinQ, out_ready,
        input  in_ready, out_valid, d, q
    );

    // The transform block itself
    modport slave (
        input  in_valid, A, B, C, CosQ, SinQ, out_ready,
        output in_ready, out_valid, d, q
    );
endinterface

// File: rtl/abc_to_dq_seq.sv
// Forward Clarke+Park (A,B,C,cos,sin -> d,q) on one shared sign-magnitude multiplier and one adder.
// Latency: out_valid is high after the 5th edge following the accepting edge; initiation interval 7.
// Backpressure: in_ready only in IDLE; d/q held in DONE until out_ready. Macro ABC_TO_DQ_SAT_EN saturates.
module abc_to_dq_seq #(
    parameter int             N           = 24,
    parameter int             Q           = 12,
    parameter logic [Q-1:0]   K_INV_SQRT3 = 12'h93D
) (
    input  logic          clk,
    input  logic          rst,
    abc_to_dq_seq_if.slave bus
);

`ifdef ABC_TO_DQ_SAT_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    localparam logic [N-1:0] K_WORD = {{(N-Q){1'b0}}, K_INV_SQRT3};

    typedef enum logic [2:0] {
        S_IDLE, S_BETA, S_P1, S_P2, S_P3, S_P4, S_DONE
    } state_t;

    state_t       state, state_nxt;
    logic [N-1:0] alpha_r, cos_r, sin_r, diff_r, beta_r;
    logic [N-1:0] p1_r, p2_r, p3_r, d_acc_r, d_r, q_r;
    logic [N-1:0] mul_a, mul_b, mul_res;
    logic [N-1:0] add_a, add_b, add_res;
    logic         add_sub;

    // Magnitude product, truncated toward zero; high bits wrap or clamp.
    function automatic logic [N-1:0] sm_mul(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [2*N-3:0] prod;
        logic [2*N-3:0] prod_sh;
        logic [N-2:0]   mag;
        prod    = {{(N-1){1'b0}}, a[N-2:0]} * {{(N-1){1'b0}}, b[N-2:0]};
        prod_sh = prod >> Q;
        mag     = prod_sh[N-2:0] | {(N-1){(|prod_sh[2*N-3:N-1]) & SAT_EN}};
        return (mag == '0) ? '0 : {a[N-1] ^ b[N-1], mag};
    endfunction

    // Compare-and-subtract adder; a zero magnitude never carries a minus sign.
    function automatic logic [N-1:0] sm_addsub(input logic [N-1:0] a, input logic [N-1:0] b,
                                               input logic sub);
        logic         b_sign;
        logic [N-1:0] sum;
        logic [N-2:0] mag;
        logic         sign;
        b_sign = b[N-1] ^ sub;
        sum    = '0;
        if (a[N-1] == b_sign) begin
            sum  = {1'b0, a[N-2:0]} + {1'b0, b[N-2:0]};
            mag  = sum[N-2:0] | {(N-1){sum[N-1] & SAT_EN}};
            sign = a[N-1];
        end else if (a[N-2:0] >= b[N-2:0]) begin
            mag  = a[N-2:0] - b[N-2:0];
            sign = a[N-1];
        end else begin
            mag  = b[N-2:0] - a[N-2:0];
            sign = b_sign;
        end
        return (mag == '0) ? '0 : {sign, mag};
    endfunction

    assign mul_res = sm_mul(mul_a, mul_b);
    assign add_res = sm_addsub(add_a, add_b, add_sub);

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = (state == S_DONE);
    assign bus.d         = d_r;
    assign bus.q         = q_r;

    // Multiplier operand selection per sequencing step.
    always_comb begin
        mul_a = alpha_r;
        mul_b = cos_r;
        case (state)
            S_BETA:  begin mul_a = diff_r;  mul_b = K_WORD; end
            S_P2:    begin mul_a = beta_r;  mul_b = sin_r;  end
            S_P3:    begin mul_a = beta_r;  mul_b = cos_r;  end
            S_P4:    begin mul_a = alpha_r; mul_b = sin_r;  end
            default: ;
        endcase
    end

    // Adder operand selection: B-C at accept, p1+p2 in P3, p3-(alpha*sin) chained in P4.
    always_comb begin
        add_a   = p1_r;
        add_b   = p2_r;
        add_sub = 1'b0;
        case (state)
            S_IDLE:  begin add_a = bus.B; add_b = bus.C;   add_sub = 1'b1; end
            S_P4:    begin add_a = p3_r;  add_b = mul_res; add_sub = 1'b1; end
            default: ;
        endcase
    end

    // Next-state: one step per cycle, DONE waits for the output handshake.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.in_valid) state_nxt = S_BETA;
            S_BETA:  state_nxt = S_P1;
            S_P1:    state_nxt = S_P2;
            S_P2:    state_nxt = S_P3;
            S_P3:    state_nxt = S_P4;
            S_P4:    state_nxt = S_DONE;
            S_DONE:  if (bus.out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Datapath registers; d/q outputs only change on entry to DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            alpha_r <= '0; cos_r <= '0; sin_r <= '0; diff_r <= '0; beta_r <= '0;
            p1_r    <= '0; p2_r  <= '0; p3_r  <= '0; d_acc_r <= '0;
            d_r     <= '0; q_r   <= '0;
        end else begin
            case (state)
                S_IDLE: if (bus.in_valid) begin
                    alpha_r <= bus.A;
                    cos_r   <= bus.CosQ;
                    sin_r   <= bus.SinQ;
                    diff_r  <= add_res;
                end
                S_BETA: beta_r <= mul_res;
                S_P1:   p1_r   <= mul_res;
                S_P2:   p2_r   <= mul_res;
                S_P3: begin
                    p3_r    <= mul_res;
                    d_acc_r <= add_res;
                end
                S_P4: begin
                    d_r <= d_acc_r;
                    q_r <= add_res;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_abc_to_dq_seq.sv
// Self-checking bench for abc_to_dq_seq: directed vectors, backpressure, mid-run reset, random traffic.
// Latency: expects out_valid 5 edges after the accepting edge.
// Backpressure: drives out_ready low/high to exercise stalls and back-to-back handshakes.
module tb_abc_to_dq_seq;

    localparam int     LAT  = 5;
    localparam longint MAXM = 64'd8388607;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    abc_to_dq_seq_if #(.N(24)) bus ();

    abc_to_dq_seq #(.N(24), .Q(12), .K_INV_SQRT3(12'h93D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: plain signed integer arithmetic on the real values.
    function automatic longint sm2i(input logic [23:0] x);
        longint m;
        m = longint'(x[22:0]);
        return x[23] ? -m : m;
    endfunction

    function automatic logic [23:0] i2sm(input longint v);
        longint m;
        logic   s;
        logic [23:0] r;
        m = (v < 0) ? -v : v;
`ifdef ABC_TO_DQ_SAT_EN
        if (m > MAXM) m = MAXM;
`else
        m = m % (MAXM + 1);
`endif
        s = (v < 0);
        r = {s, m[22:0]};
        return (m == 0) ? 24'h0 : r;
    endfunction

    function automatic logic [23:0] m_mul(input logic [23:0] a, input logic [23:0] b);
        return i2sm((sm2i(a) * sm2i(b)) / 4096);
    endfunction

    function automatic logic [23:0] m_add(input logic [23:0] a, input logic [23:0] b);
        return i2sm(sm2i(a) + sm2i(b));
    endfunction

    function automatic logic [23:0] m_sub(input logic [23:0] a, input logic [23:0] b);
        return i2sm(sm2i(a) - sm2i(b));
    endfunction

    task automatic model(input logic [23:0] a, b, c, cs, sn, output logic [23:0] ed, eq);
        logic [23:0] beta;
        beta = m_mul(m_sub(b, c), 24'h00093D);
        ed   = m_add(m_mul(a, cs), m_mul(beta, sn));
        eq   = m_sub(m_mul(beta, cs), m_mul(a, sn));
    endtask

    function automatic logic [23:0] rnd_sm(input int scale);
        logic [22:0] m;
        case (scale)
            0:       m = 23'($urandom_range(0, 24'h1000));
            1:       m = 23'($urandom_range(0, 24'h20000));
            default: m = 23'($urandom);
        endcase
        return {1'($urandom_range(0, 1)), m};
    endfunction

    // Present one sample (caller is at #1 after an edge, DUT in IDLE); wait bounded for out_valid.
    task automatic do_sample(input logic [23:0] a, b, c, cs, sn, output int lat);
        bus.A = a; bus.B = b; bus.C = c; bus.CosQ = cs; bus.SinQ = sn;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.A = $urandom; bus.B = $urandom; bus.C = $urandom;
        bus.CosQ = $urandom; bus.SinQ = $urandom;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic do_handshake();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.d !== 24'h0) begin errors++; $display("FAIL reset_d got=%h exp=000000", bus.d); end
        checks++; if (bus.q !== 24'h0) begin errors++; $display("FAIL reset_q got=%h exp=000000", bus.q); end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [23:0] va [4] = '{24'h001000, 24'h001000, 24'h000000, 24'h7FF000};
        logic [23:0] vb [4] = '{24'h800800, 24'h800800, 24'h000DDB, 24'h000000};
        logic [23:0] vc [4] = '{24'h800800, 24'h800800, 24'h800DDB, 24'h000000};
        logic [23:0] vcs[4] = '{24'h001000, 24'h000000, 24'h001000, 24'h7FF000};
        logic [23:0] vsn[4] = '{24'h000000, 24'h001000, 24'h000000, 24'h000000};
`ifdef ABC_TO_DQ_SAT_EN
        logic [23:0] ed [4] = '{24'h001000, 24'h000000, 24'h000000, 24'h7FFFFF};
`else
        logic [23:0] ed [4] = '{24'h001000, 24'h000000, 24'h000000, 24'h001000};
`endif
        logic [23:0] eq [4] = '{24'h000000, 24'h801000, 24'h001000, 24'h000000};
        int lat;
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL dir%0d_in_ready got=%b exp=1", i, bus.in_ready); end
            do_sample(va[i], vb[i], vc[i], vcs[i], vsn[i], lat);
            checks++; if (lat !== LAT) begin errors++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, LAT); end
            checks++; if (bus.d !== ed[i]) begin errors++; $display("FAIL dir%0d_d got=%h exp=%h", i, bus.d, ed[i]); end
            checks++; if (bus.q !== eq[i]) begin errors++; $display("FAIL dir%0d_q got=%h exp=%h", i, bus.q, eq[i]); end
            do_handshake();
            checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                errors++; $display("FAIL dir%0d_after_hs out_valid=%b in_ready=%b exp 0/1", i, bus.out_valid, bus.in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [23:0] a, b, c, cs, sn, ed, eq;
        int lat, stray;
        a = rnd_sm(1); b = rnd_sm(1); c = rnd_sm(1); cs = rnd_sm(0); sn = rnd_sm(0);
        model(a, b, c, cs, sn, ed, eq);
        do_sample(a, b, c, cs, sn, lat);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL bp_latency got=%0d exp=%0d", lat, LAT); end
        for (int k = 0; k < 10; k++) begin
            bus.in_valid = k[0];
            bus.A = $urandom; bus.B = $urandom; bus.C = $urandom;
            bus.CosQ = $urandom; bus.SinQ = $urandom;
            @(posedge clk); #1;
            checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold%0d out_valid=%b in_ready=%b exp 1/0", k, bus.out_valid, bus.in_ready);
            end
            checks++; if (bus.d !== ed || bus.q !== eq) begin
                errors++; $display("FAIL bp_data%0d d=%h q=%h exp d=%h q=%h", k, bus.d, bus.q, ed, eq);
            end
        end
        bus.in_valid = 1'b0;
        do_handshake();
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release out_valid=%b in_ready=%b exp 0/1", bus.out_valid, bus.in_ready);
        end
        stray = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) stray++;
        end
        checks++; if (stray !== 0) begin errors++; $display("FAIL bp_no_stray_accept cycles=%0d exp=0", stray); end
        checks++; if (bus.d !== ed || bus.q !== eq) begin
            errors++; $display("FAIL bp_hold_after_hs d=%h q=%h exp d=%h q=%h", bus.d, bus.q, ed, eq);
        end
    endtask

    task automatic test_mid_reset();
        logic [23:0] a, b, c, cs, sn, ed, eq;
        int lat, stray;
        bus.A = 24'h003000; bus.B = 24'h001000; bus.C = 24'h800400;
        bus.CosQ = 24'h000800; bus.SinQ = 24'h000C00;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL mrst_ctrl out_valid=%b in_ready=%b exp 0/1", bus.out_valid, bus.in_ready);
        end
        checks++; if (bus.d !== 24'h0 || bus.q !== 24'h0) begin
            errors++; $display("FAIL mrst_data d=%h q=%h exp 000000/000000", bus.d, bus.q);
        end
        stray = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0) stray++;
        end
        checks++; if (stray !== 0) begin errors++; $display("FAIL mrst_discard cycles=%0d exp=0", stray); end
        a = rnd_sm(1); b = rnd_sm(1); c = rnd_sm(1); cs = rnd_sm(0); sn = rnd_sm(0);
        model(a, b, c, cs, sn, ed, eq);
        do_sample(a, b, c, cs, sn, lat);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL mrst_latency got=%0d exp=%0d", lat, LAT); end
        checks++; if (bus.d !== ed || bus.q !== eq) begin
            errors++; $display("FAIL mrst_result d=%h q=%h exp d=%h q=%h", bus.d, bus.q, ed, eq);
        end
        do_handshake();
    endtask

    task automatic test_back_to_back();
        logic [23:0] a, b, c, cs, sn, ed, eq;
        int lat, sc;
        for (int i = 0; i < 40; i++) begin
            sc = (i % 5 == 4) ? 2 : int'($urandom_range(0, 1));
            a = rnd_sm(sc); b = rnd_sm(sc); c = rnd_sm(sc);
            cs = rnd_sm(i % 7 == 6 ? 2 : 0); sn = rnd_sm(0);
            if (i % 9 == 3) begin b = 24'h000000; c = 24'h800000; end
            model(a, b, c, cs, sn, ed, eq);
            checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rnd%0d_in_ready got=%b exp=1", i, bus.in_ready); end
            bus.out_ready = $urandom_range(0, 1);
            do_sample(a, b, c, cs, sn, lat);
            checks++; if (lat !== LAT) begin errors++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, lat, LAT); end
            checks++; if (bus.d !== ed || bus.q !== eq) begin
                errors++; $display("FAIL rnd%0d_result a=%h b=%h c=%h cos=%h sin=%h d=%h q=%h exp d=%h q=%h",
                                   i, a, b, c, cs, sn, bus.d, bus.q, ed, eq);
            end
            if (bus.out_ready !== 1'b1) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                do_handshake();
            end else begin
                @(posedge clk); #1;
                bus.out_ready = 1'b0;
            end
            checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                errors++; $display("FAIL rnd%0d_after_hs out_valid=%b in_ready=%b exp 0/1", i, bus.out_valid, bus.in_ready);
            end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.A = '0; bus.B = '0; bus.C = '0; bus.CosQ = '0; bus.SinQ = '0;
        test_reset();
        test_directed();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
